disk_access_scheduler: RTL

- Sequences and shares the single-port disk_controller between two requesters: CPU single-word reads/writes and a block-transfer (DMA) engine that copies consecutive disk words into main memory, e.g. loading a program image before execution.
- Issues the disk read/write strobes, waits for done, enforces a per-access timeout and fair per-word arbitration.
- Sits between the CPU/memory datapath and disk_controller.

---
 rtl/disk_access_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/disk_access_scheduler.sv
// Shares the single-port disk controller between CPU word accesses and a
// disk-to-memory block-transfer engine, with per-access timeout and word-level fair arbitration.
module disk_access_scheduler #(
    parameter int MEM_AW         = 10,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [14:0]       cpu_disk_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_start,
    input  logic [14:0]       dma_disk_base,
    input  logic [MEM_AW-1:0] dma_mem_base,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        disk_track,
    output logic [4:0]        disk_sector,
    output logic [6:0]        disk_addr,
    output logic              disk_read,
    output logic              disk_write,
    output logic [31:0]       disk_wdata,
    input  logic [31:0]       disk_rdata,
    input  logic              disk_read_done,
    input  logic              disk_write_done,
    output logic              timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_RD, DMA_MEM} state_t;

    state_t            state_q, state_d;
    logic              last_dma_q, last_dma_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [14:0]       dma_disk_q, dma_disk_d;
    logic [MEM_AW-1:0] dma_mem_q, dma_mem_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_busy_q, dma_busy_d;
    logic              dma_done_q, dma_done_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [14:0]       dsk_addr_q, dsk_addr_d;
    logic              disk_read_q, disk_read_d;
    logic              disk_write_q, disk_write_d;
    logic [31:0]       disk_wdata_q, disk_wdata_d;
    logic              timeout_err_q, timeout_err_d;

    logic dma_pend, grant_cpu, grant_dma, cpu_done, tmo_hit;

    always_comb begin
        state_d       = state_q;
        last_dma_d    = last_dma_q;
        tmo_d         = tmo_q;
        rem_d         = rem_q;
        dma_disk_d    = dma_disk_q;
        dma_mem_d     = dma_mem_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_ack_d     = 1'b0;
        dma_busy_d    = dma_busy_q;
        dma_done_d    = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        dsk_addr_d    = dsk_addr_q;
        disk_read_d   = disk_read_q;
        disk_write_d  = disk_write_q;
        disk_wdata_d  = disk_wdata_q;
        timeout_err_d = timeout_err_q;

        dma_pend  = (rem_q != '0);
        grant_cpu = cpu_req && (!dma_pend || last_dma_q);
        grant_dma = dma_pend && !grant_cpu;
        cpu_done  = disk_read_q ? disk_read_done : disk_write_done;
        tmo_hit   = (tmo_q == TMO_LAST);

        // A start can only be accepted while no transfer is running, so it never collides with DMA_MEM/abort updates
        if (dma_start && !dma_busy_q) begin
            dma_disk_d = dma_disk_base;
            dma_mem_d  = dma_mem_base;
            rem_d      = dma_len;
            if (dma_len == '0) dma_done_d = 1'b1;
            else               dma_busy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    state_d      = CPU_ACC;
                    last_dma_d   = 1'b0;
                    tmo_d        = '0;
                    dsk_addr_d   = cpu_disk_addr;
                    disk_read_d  = !cpu_we;
                    disk_write_d = cpu_we;
                    if (cpu_we) disk_wdata_d = cpu_wdata;
                end else if (grant_dma) begin
                    state_d     = DMA_RD;
                    last_dma_d  = 1'b1;
                    tmo_d       = '0;
                    dsk_addr_d  = dma_disk_q;
                    disk_read_d = 1'b1;
                end
            end
            CPU_ACC: begin
                if (cpu_done || tmo_hit) begin
                    state_d      = IDLE;
                    disk_read_d  = 1'b0;
                    disk_write_d = 1'b0;
                    cpu_ack_d    = 1'b1;
                    if (!cpu_done) begin
                        cpu_rdata_d   = '0;
                        timeout_err_d = 1'b1;
                    end else if (disk_read_q) begin
                        cpu_rdata_d = disk_rdata;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DMA_RD: begin
                if (disk_read_done) begin
                    state_d     = DMA_MEM;
                    disk_read_d = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = dma_mem_q;
                    mem_wdata_d = disk_rdata;
                end else if (tmo_hit) begin
                    state_d       = IDLE;
                    disk_read_d   = 1'b0;
                    rem_d         = '0;
                    dma_done_d    = 1'b1;
                    dma_busy_d    = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DMA_MEM: begin
                state_d    = IDLE;
                dma_disk_d = dma_disk_q + 15'd1;
                dma_mem_d  = dma_mem_q + MEM_AW'(1);
                rem_d      = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    dma_done_d = 1'b1;
                    dma_busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_dma_q    <= 1'b1;
            tmo_q         <= '0;
            rem_q         <= '0;
            dma_disk_q    <= '0;
            dma_mem_q     <= '0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            dma_busy_q    <= 1'b0;
            dma_done_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            dsk_addr_q    <= '0;
            disk_read_q   <= 1'b0;
            disk_write_q  <= 1'b0;
            disk_wdata_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_dma_q    <= last_dma_d;
            tmo_q         <= tmo_d;
            rem_q         <= rem_d;
            dma_disk_q    <= dma_disk_d;
            dma_mem_q     <= dma_mem_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_busy_q    <= dma_busy_d;
            dma_done_q    <= dma_done_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            dsk_addr_q    <= dsk_addr_d;
            disk_read_q   <= disk_read_d;
            disk_write_q  <= disk_write_d;
            disk_wdata_q  <= disk_wdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign dma_busy    = dma_busy_q;
    assign dma_done    = dma_done_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disk_track  = dsk_addr_q[14:12];
    assign disk_sector = dsk_addr_q[11:7];
    assign disk_addr   = dsk_addr_q[6:0];
    assign disk_read   = disk_read_q;
    assign disk_write  = disk_write_q;
    assign disk_wdata  = disk_wdata_q;
    assign timeout_err = timeout_err_q;
endmodule
